// File: rtl/bch_pkg.sv
// Shared constants, GF(2^M) types and arithmetic helpers for the BCH(N,K) t=2 decoder.
package bch_pkg;

    localparam int N    = 15;
    localparam int K    = 7;
    localparam int M    = 4;
    localparam int DROP = 0;
    localparam int W    = N - DROP;
    localparam int V    = K - DROP;
    localparam int Q    = (1 << M) - 1;

    localparam logic [M:0]   PRIM_POLY = 5'b10011;
    localparam logic [N-K:0] GEN_POLY  = 9'b111010001;

    typedef logic [M-1:0] gf_t;

    typedef enum logic [2:0] {IDLE, SYND, SOLVE, CHIEN, DONE} dec_state_t;

    // Shift/xor multiply, reducing by the primitive polynomial at each shift.
    function automatic gf_t gf_mul(input gf_t a, input gf_t b);
        gf_t acc;
        gf_t x;
        acc = '0;
        x   = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[M-1] ? ((x << 1) ^ PRIM_POLY[M-1:0]) : (x << 1);
        end
        return acc;
    endfunction

    // alpha^e, exponent taken modulo the multiplicative group order.
    function automatic gf_t gf_pow(input int e);
        gf_t r;
        r = gf_t'(1);
        for (int i = 0; i < Q; i++) begin
            if (i < (e % Q)) r = gf_mul(r, gf_t'(2));
        end
        return r;
    endfunction

    localparam gf_t ALPHA1 = gf_pow(1);
    localparam gf_t ALPHA2 = gf_pow(2);
    localparam gf_t ALPHA3 = gf_pow(3);

    // Chien starts at position W-1, i.e. evaluates sigma at alpha^-(W-1).
    localparam gf_t CHIEN_INIT1 = gf_pow((Q - ((W - 1) % Q)) % Q);
    localparam gf_t CHIEN_INIT2 = gf_pow((Q - ((2 * (W - 1)) % Q)) % Q);

    // Multiplicative inverses in GF(16) with x^4+x+1; entry 0 is a don't-care.
    localparam gf_t GF_INV [0:(1 << M) - 1] = '{
        4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
        4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8
    };

endpackage

// File: rtl/bch_chien_search.sv
// Chien search engine: steps sigma(alpha^-p) from p=W-1 down to 0 and counts roots.
module bch_chien_search
    import bch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    input  gf_t        sig1,
    input  gf_t        sig2,
    output logic       hit,
    output logic [1:0] root_count
);

    gf_t t1;
    gf_t t2;

    assign hit = ((gf_t'(1) ^ t1 ^ t2) == '0);

    // Term registers: preload at the first position, then advance one position per step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t1         <= '0;
            t2         <= '0;
            root_count <= '0;
        end else if (load) begin
            t1         <= gf_mul(sig1, CHIEN_INIT1);
            t2         <= gf_mul(sig2, CHIEN_INIT2);
            root_count <= '0;
        end else if (step) begin
            t1         <= gf_mul(t1, ALPHA1);
            t2         <= gf_mul(t2, ALPHA2);
            root_count <= root_count + {1'b0, hit};
        end
    end

endmodule

// File: rtl/serial_bch_decoder.sv
// Serial t=2 BCH decoder: bit-serial syndromes, single-cycle locator solve,
// Chien search with in-place correction of the working register.
// Optional build macro BCH_DEC_EARLY_EXIT_EN: zero-syndrome words skip the
// Chien search and report straight from SOLVE.
module serial_bch_decoder
    import bch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         kick_off,
    input  logic [W-1:0] codeword_in,
    output logic [V-1:0] data_out,
    output logic         busy,
    output logic         output_valid,
    output logic [1:0]   err_count,
    output logic         uncorrectable
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    dec_state_t    state;
    dec_state_t    state_next;
    logic [W-1:0]  work;
    logic [V-1:0]  raw_msg;
    logic [CW-1:0] cnt;
    gf_t           s1;
    gf_t           s3;
    gf_t           s1_cube;
    gf_t           sig1;
    gf_t           sig2;
    logic [1:0]    deg_c;
    logic [1:0]    deg_r;
    logic          unc_c;
    logic          unc_r;
    logic          early_exit;
    logic          hit;
    logic [1:0]    root_count;
    logic [1:0]    final_count;
    logic [W-1:0]  flip_mask;
    logic [W-1:0]  work_flip;
    logic          bad_word;
    logic          chien_load;
    logic          chien_step;

`ifdef BCH_DEC_EARLY_EXIT_EN
    assign early_exit = (s1 == '0) && (s3 == '0);
`else
    assign early_exit = 1'b0;
`endif

    assign s1_cube     = gf_mul(gf_mul(s1, s1), s1);
    assign flip_mask   = {{(W-1){1'b0}}, hit} << cnt;
    assign work_flip   = work ^ flip_mask;
    assign final_count = root_count + {1'b0, hit};
    assign bad_word    = unc_r || (final_count != deg_r);
    assign chien_load  = en && (state == SOLVE) && !kick_off;
    assign chien_step  = en && (state == CHIEN) && !kick_off;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else if (en) state <= state_next;
    end

    // Next-state: kick_off restarts from any state, otherwise walk the decode phases.
    always_comb begin
        state_next = state;
        if (kick_off) begin
            state_next = SYND;
        end else begin
            case (state)
                SYND:    if (cnt == '0) state_next = SOLVE;
                SOLVE:   state_next = early_exit ? DONE : CHIEN;
                CHIEN:   if (cnt == '0) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Status outputs decoded from state.
    always_comb begin
        busy         = 1'b0;
        output_valid = 1'b0;
        case (state)
            SYND, SOLVE, CHIEN: busy = 1'b1;
            DONE:               output_valid = 1'b1;
            default:            ;
        endcase
    end

    // Direct t=2 solve of sigma(x) = 1 + sig1*x + sig2*x^2 from S1/S3.
    always_comb begin
        sig1  = '0;
        sig2  = '0;
        deg_c = 2'd0;
        unc_c = 1'b0;
        if (s1 == '0) begin
            unc_c = (s3 != '0);
        end else begin
            sig1 = s1;
            if (s3 != s1_cube) begin
                sig2  = gf_mul(s3 ^ s1_cube, GF_INV[s1]);
                deg_c = 2'd2;
            end else begin
                deg_c = 2'd1;
            end
        end
    end

    // Datapath: capture, syndromes, solve results, in-place correction and result latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work          <= '0;
            raw_msg       <= '0;
            cnt           <= '0;
            s1            <= '0;
            s3            <= '0;
            deg_r         <= '0;
            unc_r         <= 1'b0;
            data_out      <= '0;
            err_count     <= '0;
            uncorrectable <= 1'b0;
        end else if (en) begin
            if (kick_off) begin
                work          <= codeword_in;
                raw_msg       <= codeword_in[W-1 -: V];
                cnt           <= CNT_TOP;
                s1            <= '0;
                s3            <= '0;
                err_count     <= '0;
                uncorrectable <= 1'b0;
            end else begin
                case (state)
                    SYND: begin
                        s1 <= gf_mul(s1, ALPHA1) ^ {{(M-1){1'b0}}, work[cnt]};
                        s3 <= gf_mul(s3, ALPHA3) ^ {{(M-1){1'b0}}, work[cnt]};
                        if (cnt != '0) cnt <= cnt - CW'(1);
                    end
                    SOLVE: begin
                        cnt   <= CNT_TOP;
                        deg_r <= deg_c;
                        unc_r <= unc_c;
                        if (early_exit) begin
                            data_out      <= work[W-1 -: V];
                            err_count     <= '0;
                            uncorrectable <= 1'b0;
                        end
                    end
                    CHIEN: begin
                        work <= work_flip;
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else if (bad_word) begin
                            data_out      <= raw_msg;
                            err_count     <= '0;
                            uncorrectable <= 1'b1;
                        end else begin
                            data_out      <= work_flip[W-1 -: V];
                            err_count     <= final_count;
                            uncorrectable <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    bch_chien_search u_chien (
        .clk        (clk),
        .reset      (reset),
        .load       (chien_load),
        .step       (chien_step),
        .sig1       (sig1),
        .sig2       (sig2),
        .hit        (hit),
        .root_count (root_count)
    );

endmodule

// File: tb/tb_serial_bch_decoder.sv
// Directed bench for serial_bch_decoder (BCH(15,7), t=2). Honours BCH_DEC_EARLY_EXIT_EN
// for the clean-word latency expectation.
module tb_serial_bch_decoder;

    localparam int W = 15;
    localparam int V = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         kick_off;
    logic [W-1:0] codeword_in;
    logic [V-1:0] data_out;
    logic         busy;
    logic         output_valid;
    logic [1:0]   err_count;
    logic         uncorrectable;

    int checks   = 0;
    int failures = 0;

    serial_bch_decoder dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .kick_off      (kick_off),
        .codeword_in   (codeword_in),
        .data_out      (data_out),
        .busy          (busy),
        .output_valid  (output_valid),
        .err_count     (err_count),
        .uncorrectable (uncorrectable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Systematic encoder: parity = m(x)*x^8 mod g(x).
    function automatic logic [W-1:0] encode(input logic [V-1:0] msg);
        logic [W-1:0] r;
        logic [W-1:0] g;
        g = 15'b000000111010001;
        r = {msg, 8'h00};
        for (int i = W - 1; i >= 8; i--) begin
            if (r[i]) r = r ^ (g << (i - 8));
        end
        return {msg, r[7:0]};
    endfunction

    // Present a word; returns at the first sampling point after the kick edge (cycle 1).
    task automatic kick(input logic [W-1:0] word);
        @(negedge clk);
        codeword_in = word;
        kick_off    = 1'b1;
        @(negedge clk);
        kick_off    = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int n);
        n = start;
        while (!output_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", {31'd0, output_valid}, 32'd1);
    endtask

    task automatic decode(input logic [W-1:0] word, output int lat);
        kick(word);
        wait_valid(1, lat);
    endtask

    int           lat;
    int           clean_lat;
    logic         seen;
    logic [W-1:0] cw;
    int           p0, p1, p2;

    initial begin
`ifdef BCH_DEC_EARLY_EXIT_EN
        clean_lat = 17;
`else
        clean_lat = 32;
`endif
        reset       = 1'b1;
        en          = 1'b1;
        kick_off    = 1'b0;
        codeword_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy},          32'd0);
        check("rst_valid", {31'd0, output_valid},  32'd0);
        check("rst_data",  {25'd0, data_out},      32'd0);
        check("rst_err",   {30'd0, err_count},     32'd0);
        check("rst_unc",   {31'd0, uncorrectable}, 32'd0);
        reset = 1'b0;

        decode(15'h40E8, lat);
        check("clean_lat",  lat,                        clean_lat);
        check("clean_data", {25'd0, data_out},          32'h40);
        check("clean_err",  {30'd0, err_count},         32'd0);
        check("clean_unc",  {31'd0, uncorrectable},     32'd0);

        decode(15'h40E9, lat);
        check("single_lat",  lat,                       32);
        check("single_data", {25'd0, data_out},         32'h40);
        check("single_err",  {30'd0, err_count},        32'd1);
        check("single_unc",  {31'd0, uncorrectable},    32'd0);

        decode(15'h00E0, lat);
        check("double_lat",  lat,                       32);
        check("double_data", {25'd0, data_out},         32'h40);
        check("double_err",  {30'd0, err_count},        32'd2);
        check("double_unc",  {31'd0, uncorrectable},    32'd0);

        // Loopback over every message with 0, 1 and 2 distinct random errors.
        for (int m = 0; m < 128; m++) begin
            for (int ne = 0; ne < 3; ne++) begin
                cw = encode(m[V-1:0]);
                p0 = $urandom_range(W - 1);
                p1 = $urandom_range(W - 1);
                while (p1 == p0) p1 = $urandom_range(W - 1);
                if (ne >= 1) cw[p0] = ~cw[p0];
                if (ne >= 2) cw[p1] = ~cw[p1];
                decode(cw, lat);
                check("loop_data", {25'd0, data_out},      32'(m));
                check("loop_err",  {30'd0, err_count},     32'(ne));
                check("loop_unc",  {31'd0, uncorrectable}, 32'd0);
            end
        end

        // Three errors: must not report a clean recovery, never more than 2 corrections.
        for (int m = 0; m < 128; m += 4) begin
            cw = encode(m[V-1:0]);
            p0 = $urandom_range(W - 1);
            p1 = $urandom_range(W - 1);
            while (p1 == p0) p1 = $urandom_range(W - 1);
            p2 = $urandom_range(W - 1);
            while (p2 == p0 || p2 == p1) p2 = $urandom_range(W - 1);
            cw[p0] = ~cw[p0];
            cw[p1] = ~cw[p1];
            cw[p2] = ~cw[p2];
            decode(cw, lat);
            check("triple_flag", {31'd0, (uncorrectable || (data_out != m[V-1:0]))}, 32'd1);
            check("triple_cnt",  {31'd0, (err_count <= 2'd2)},                      32'd1);
        end

        // Abort: second kick_off at cycle 10 of a running decode.
        seen = 1'b0;
        kick(15'h00E0);
        repeat (8) begin
            @(negedge clk);
            seen = seen | output_valid;
        end
        kick(15'h40E9);
        wait_valid(1, lat);
        check("abort_no_early", {31'd0, seen},          32'd0);
        check("abort_lat",      lat,                    32);
        check("abort_err",      {30'd0, err_count},     32'd1);
        check("abort_data",     {25'd0, data_out},      32'h40);
        @(negedge clk);
        check("abort_one_pulse", {31'd0, output_valid}, 32'd0);

        // en low for 5 cycles mid-CHIEN delays output_valid by exactly 5.
        kick(15'h40E9);
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
        end
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        wait_valid(25, lat);
        check("stall_lat",  lat,                   37);
        check("stall_err",  {30'd0, err_count},    32'd1);
        check("stall_data", {25'd0, data_out},     32'h40);

        // Async reset between edges during CHIEN clears outputs immediately.
        kick(15'h00E0);
        repeat (21) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy",  {31'd0, busy},          32'd0);
        check("arst_valid", {31'd0, output_valid},  32'd0);
        check("arst_data",  {25'd0, data_out},      32'd0);
        check("arst_err",   {30'd0, err_count},     32'd0);
        check("arst_unc",   {31'd0, uncorrectable}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        decode(15'h40E9, lat);
        check("post_rst_lat",  lat,                   32);
        check("post_rst_data", {25'd0, data_out},     32'h40);
        check("post_rst_err",  {30'd0, err_count},    32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
